bcd_seq_add_ctrl: RTL and testbench
===================================

BCD_SEQ_ADD_CTRL -- requirements
Module: bcd_seq_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: NDIG, default 4, the number of BCD digits per operand (legal 2..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin an addition.
REQ-005 The block SHALL have port op_a, input, 4*NDIG, operand A as packed BCD, digit 0 in bits [3:0].
REQ-006 The block SHALL have port op_b, input, 4*NDIG, operand B as packed BCD.
REQ-007 The block SHALL have port cin, input, 1, the carry-in to digit 0.
REQ-008 The block SHALL have port busy, output, 1, high while digits are being added.
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port sum, output, 4*NDIG, the packed BCD result.
REQ-011 The block SHALL have port cout, output, 1, the carry out of the top digit.
REQ-012 The block SHALL have port err, output, 1, flagging an invalid operand digit or a bad digit-adder response.
REQ-013 The block SHALL have port dig_a, output, 4, the A digit driven to the external one-digit BCD adder.
REQ-014 The block SHALL have port dig_b, output, 4, the B digit driven to the digit adder.
REQ-015 The block SHALL have port dig_c, output, 1, the carry driven to the digit adder.
REQ-016 The block SHALL have port dig_s1, input, 4, the tens digit from the digit adder (combinational; 0 or 1 when legal).
REQ-017 The block SHALL have port dig_s0, input, 4, the units digit from the digit adder.

Function
REQ-018 The FSM SHALL have states IDLE, ADD and DONE.
REQ-019 A start SHALL be accepted in IDLE or DONE and SHALL be ignored in ADD.
REQ-020 On acceptance the block SHALL latch op_a, op_b and cin, clear sum, cout and err, and set the digit index to 0.
REQ-021 On acceptance, if any latched digit of op_a or op_b is greater than 9, the block SHALL go directly to DONE with err=1, sum=0 and cout=0.
REQ-022 Otherwise, on acceptance, the block SHALL enter ADD.
REQ-023 In ADD, combinationally, dig_a and dig_b SHALL be digit[idx] of the latched operands, and dig_c SHALL be the running carry (initialised to cin).
REQ-024 On each ADD edge the block SHALL store dig_s0 into sum digit idx, set carry to dig_s1[0], and increment idx.
REQ-025 If dig_s1 > 1 or dig_s0 > 9 on an ADD edge, the block SHALL set err=1, which stays set until the next accepted start; the digit is still stored and the sequence still completes.
REQ-026 When idx = NDIG-1 on an ADD edge, the block SHALL set cout to the final carry and go to DONE.
REQ-027 Latency: for a start accepted at edge k, done SHALL be high in the cycle after edge k+NDIG (one cycle after edge k when REQ-021 applies).
REQ-028 busy SHALL be 1 exactly in ADD.
REQ-029 done SHALL be 1 exactly in DONE, and DONE SHALL last one cycle, returning to IDLE unless start is accepted.
REQ-030 sum, cout and err SHALL hold their final values from DONE until the next accepted start.
REQ-031 Outside ADD, dig_a, dig_b and dig_c SHALL be 0.
REQ-032 Operands changing on op_a, op_b or cin during ADD SHALL have no effect on the result in progress.

Reset
REQ-033 While rst is high, the block SHALL be in IDLE with busy=0, done=0, sum=0, cout=0, err=0, dig_a=0, dig_b=0, dig_c=0, idx=0 and carry=0, taking effect immediately without a clock edge.
REQ-034 Reset asserted mid-ADD SHALL abort the addition with no done pulse; the first start accepted after rst falls SHALL behave per REQ-020 to REQ-022.

Verification
(The bench instantiates a behavioural one-digit BCD adder on the dig_* ports, with NDIG=4.)
REQ-035 A bench SHALL check: op_a=0x1234, op_b=0x5678, cin=0 -> done in the fifth cycle after the start edge with sum=0x6912, cout=0, err=0, and busy high for 4 cycles.
REQ-036 A bench SHALL check: op_a=0x9999, op_b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0.
REQ-037 A bench SHALL check: op_a=0x9999, op_b=0x9999, cin=1 -> sum=0x9999, cout=1; then a start held in the DONE cycle with op_a=0x0000, op_b=0x0000, cin=0 -> sum=0x0000, cout=0, with no idle cycle between.
REQ-038 A bench SHALL check: op_a=0x00A0, op_b=0x0001 -> done one cycle after start with err=1, sum=0, cout=0, and busy never high.
REQ-039 A bench SHALL check: start pulsed again during ADD is ignored (the result equals the first operands), and rst raised after the second ADD edge gives an immediate busy=0, sum=0, no done, and dig_a, dig_b, dig_c=0.
REQ-040 A bench SHALL check: a faulty adder model forcing dig_s1=2 on digit 1 -> err=1 at done and the sequence still completes in 4 ADD cycles.

Source files
------------

// File: rtl/bcd_seq_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seq_add_ctrl
//  Purpose  : Sequential multi-digit BCD adder controller. Adds two packed BCD
//             operands one digit per clock using an external combinational
//             one-digit BCD adder, ripple-carrying between digits.
//  Ports    : clk, rst (async, active-high)
//             start          - request an addition (accepted in IDLE/DONE)
//             op_a, op_b     - packed BCD operands, digit 0 in bits [3:0]
//             cin            - carry into digit 0
//             busy           - high while digits are being added
//             done           - one-cycle completion pulse
//             sum, cout      - packed BCD result and top-digit carry
//             err            - invalid operand digit or bad adder response
//             dig_a/b/c      - operand digits and carry to the digit adder
//             dig_s1/s0      - tens/units digit returned by the digit adder
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_seq_add_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] op_a,
  input  logic [4*NDIG-1:0] op_b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err,
  output logic [3:0]        dig_a,
  output logic [3:0]        dig_b,
  output logic              dig_c,
  input  logic [3:0]        dig_s1,
  input  logic [3:0]        dig_s0
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [4*NDIG-1:0] a_q, a_d;
  logic [4*NDIG-1:0] b_q, b_d;
  logic [4*NDIG-1:0] sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;

  // Digit position of the current idx within the packed operands.
  logic [IW+1:0]     bit_pos;
  assign bit_pos = {idx_q, 2'b00};

  // Any digit above 9 on the incoming operands marks them unusable.
  logic [NDIG-1:0]   bad_dig;
  logic              bad_any;

  for (genvar i = 0; i < NDIG; i++) begin : g_chk
    assign bad_dig[i] = (op_a[4*i +: 4] > 4'd9) || (op_b[4*i +: 4] > 4'd9);
  end
  assign bad_any = |bad_dig;

  logic accept;
  assign accept = start && (state_q != S_ADD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          if (bad_any) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        sum_d[bit_pos +: 4] = dig_s0;
        carry_d             = dig_s1[0];
        idx_d               = idx_q + 1'b1;
        // A misbehaving digit adder is flagged but the sequence still runs out.
        if ((dig_s1 > 4'd1) || (dig_s0 > 4'd9)) begin
          err_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          cout_d  = dig_s1[0];
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == S_ADD);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

  // Digit adder is fed only while adding; idle outputs are held at zero.
  assign dig_a = busy ? a_q[bit_pos +: 4] : 4'd0;
  assign dig_b = busy ? b_q[bit_pos +: 4] : 4'd0;
  assign dig_c = busy ? carry_q : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_seq_add_ctrl
//  Purpose  : Self-checking bench for bcd_seq_add_ctrl (NDIG=4) with a
//             behavioural one-digit BCD adder on the dig_* ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seq_add_ctrl;

  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, err, dig_c;
  logic [15:0] sum;
  logic [3:0]  dig_a, dig_b, dig_s1, dig_s0;

  int total = 0;
  int bad   = 0;

  logic fault_en = 1'b0;
  int   add_cnt  = 0;

  always #5 clk = ~clk;

  bcd_seq_add_ctrl #(.NDIG(NDIG)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .err    (err),
    .dig_a  (dig_a),
    .dig_b  (dig_b),
    .dig_c  (dig_c),
    .dig_s1 (dig_s1),
    .dig_s0 (dig_s0)
  );

  // Count ADD cycles so the faulty adder can target digit 1.
  always @(posedge clk) begin
    if (start && !busy) add_cnt <= 0;
    else if (busy)      add_cnt <= add_cnt + 1;
  end

  // Behavioural one-digit BCD adder.
  always_comb begin
    logic [4:0] s;
    s = 5'(dig_a) + 5'(dig_b) + 5'(dig_c);
    if (s > 5'd9) begin
      dig_s1 = 4'd1;
      dig_s0 = 4'(s - 5'd10);
    end else begin
      dig_s1 = 4'd0;
      dig_s0 = s[3:0];
    end
    if (fault_en && busy && add_cnt == 1) dig_s1 = 4'd2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_start(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cin = c;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the start edge until done is seen (bounded).
  task automatic wait_done(input int n0, output int lat, output int nb);
    lat = n0;
    nb  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
      if (done) return;
    end
    lat = 99;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] s;
    logic        co;
    logic        e;
    int          lat;
    int          nbusy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, nb;
    bit seen;

    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5, 4};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 4};
    vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 5, 4};
    vecs[3] = '{16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 5, 4};
    vecs[5] = '{16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 5, 4};
    vecs[6] = '{16'h1234, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1, 1, 0};

    // Reset state while rst is held.
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    check("rst_dig", {dig_a, dig_b, dig_c}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors; operands are scrambled after the start edge.
    for (int i = 0; i < 7; i++) begin
      apply_start(vecs[i].a, vecs[i].b, vecs[i].c);
      op_a = 16'h8787; op_b = 16'h7878; cin = ~vecs[i].c;
      wait_done(0, lat, nb);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), nb, vecs[i].nbusy);
      check($sformatf("v%0d_sum", i), sum, vecs[i].s);
      check($sformatf("v%0d_cout", i), cout, vecs[i].co);
      check($sformatf("v%0d_err", i), err, vecs[i].e);
      @(negedge clk);
      check($sformatf("v%0d_done1", i), done, 0);
      check($sformatf("v%0d_hold", i), {sum, cout, err}, {vecs[i].s, vecs[i].co, vecs[i].e});
    end

    // Back-to-back: start held in the DONE cycle.
    apply_start(16'h9999, 16'h9999, 1'b1);
    wait_done(0, lat, nb);
    check("b2b_lat1", lat, 5);
    check("b2b_sum1", {sum, cout}, {16'h9999, 1'b1});
    start = 1'b1; op_a = 16'h0000; op_b = 16'h0000; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_noidle", {busy, done}, 2'b10);
    check("b2b_clear", {sum, cout, err}, 0);
    wait_done(1, lat, nb);
    check("b2b_lat2", lat, 5);
    check("b2b_sum2", {sum, cout, err}, 0);

    // Start during ADD is ignored; first ADD cycle drives digit 0.
    apply_start(16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    check("add_dig0", {dig_a, dig_b, dig_c}, {4'd4, 4'd8, 1'b0});
    start = 1'b1; op_a = 16'h1111; op_b = 16'h1111; cin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1, lat, nb);
    check("ign_lat", lat, 5);
    check("ign_sum", {sum, cout, err}, {16'h6912, 1'b0, 1'b0});
    @(negedge clk);

    // Reset after the second ADD edge aborts immediately.
    apply_start(16'h1234, 16'h5678, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", {sum, cout, err}, 0);
    check("abort_dig", {dig_a, dig_b, dig_c}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort_nodone", seen, 0);
    apply_start(16'h0042, 16'h0058, 1'b0);
    wait_done(0, lat, nb);
    check("post_rst_lat", lat, 5);
    check("post_rst_sum", {sum, cout, err}, {16'h0100, 1'b0, 1'b0});
    @(negedge clk);

    // Faulty digit adder on digit 1.
    fault_en = 1'b1;
    apply_start(16'h1111, 16'h2222, 1'b0);
    wait_done(0, lat, nb);
    check("fault_lat", lat, 5);
    check("fault_busy", nb, 4);
    check("fault_err", err, 1);
    check("fault_sum", {sum, cout}, {16'h3333, 1'b0});
    fault_en = 1'b0;
    @(negedge clk);
    check("fault_hold", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
